// File: rtl/data_route_pkg.sv
// Shared widths for the 128-bit <-> 1536-bit systolic data route.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_route_pkg;

  localparam int S_WIDTH_128 = 128;
  localparam int LANES_12    = 12;
  localparam int WIDE_WIDTH  = S_WIDTH_128 * LANES_12;
  localparam int LANE_CNT_W  = $clog2(LANES_12);

endpackage

// File: rtl/in128_out1536.sv
// Packs LANES narrow AXI-Stream beats into one wide word, keeping per-lane tlast.
// Latency: completing beat accepted at cycle t -> m_axis_tvalid at t+1.
// Backpressure: one-word output register plus one held accumulator; s_axis_tready drops only while both are full.
module in128_out1536
  import data_route_pkg::*;
#(
  parameter int S_WIDTH     = S_WIDTH_128,
  parameter int LANES       = LANES_12,
  parameter bit PAD_ON_LAST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [S_WIDTH-1:0]       s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [S_WIDTH*LANES-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [LANES-1:0]         m_axis_tlast
);

  localparam int LW = $clog2(LANES);
  localparam int WW = S_WIDTH * LANES;

  // Accumulator. Lanes at or above lane_cnt are kept at zero while filling,
  // so an early close needs no extra padding logic.
  logic [WW-1:0]    acc_data;
  logic [LANES-1:0] acc_last;
  logic [LW-1:0]    lane_cnt;
  logic             acc_full;

  // Output register
  logic [WW-1:0]    out_data;
  logic [LANES-1:0] out_last;
  logic             out_vld;

  logic             accept;
  logic             word_done;
  logic             out_free;
  logic [WW-1:0]    word_data;
  logic [LANES-1:0] word_last;

  assign s_axis_tready = ~acc_full;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign m_axis_tvalid = out_vld;

  assign accept    = s_axis_tvalid & ~acc_full;
  assign word_done = accept & ((lane_cnt == LW'(LANES - 1)) | (PAD_ON_LAST & s_axis_tlast));
  assign out_free  = ~out_vld | m_axis_tready;

  // Accumulator contents with the current beat dropped into lane lane_cnt
  always_comb begin
    word_data = acc_data;
    word_last = acc_last;
    for (int k = 0; k < LANES; k++) begin
      if (lane_cnt == LW'(k)) begin
        word_data[k*S_WIDTH +: S_WIDTH] = s_axis_tdata;
        word_last[k]                    = s_axis_tlast;
      end
    end
  end

  // Accumulator fill, word hand-off to the output register, and output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data <= '0;
      acc_last <= '0;
      lane_cnt <= '0;
      acc_full <= 1'b0;
      out_data <= '0;
      out_last <= '0;
      out_vld  <= 1'b0;
    end else if (acc_full) begin
      // Held word moves out as soon as the current output is taken
      if (m_axis_tready) begin
        out_data <= acc_data;
        out_last <= acc_last;
        acc_data <= '0;
        acc_last <= '0;
        acc_full <= 1'b0;
      end
    end else begin
      if (out_vld & m_axis_tready) begin
        out_vld <= 1'b0;
      end
      if (accept) begin
        if (word_done) begin
          lane_cnt <= '0;
          if (out_free) begin
            out_data <= word_data;
            out_last <= word_last;
            out_vld  <= 1'b1;
            acc_data <= '0;
            acc_last <= '0;
          end else begin
            acc_data <= word_data;
            acc_last <= word_last;
            acc_full <= 1'b1;
          end
        end else begin
          acc_data <= word_data;
          acc_last <= word_last;
          lane_cnt <= lane_cnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_in128_out1536.sv
// Bench for in128_out1536: table-driven first word, scoreboard for all word traffic.
// Latency: checks completing beat -> m_axis_tvalid one cycle later.
// Backpressure: exercises held output, full accumulator and random ready.
module tb_in128_out1536;
  import data_route_pkg::*;

  localparam int W = S_WIDTH_128;
  localparam int L = LANES_12;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   s_tdata;
  logic           s_tvalid;
  logic           s_tlast;
  logic           m_tready;

  logic           s_tready;
  logic [W*L-1:0] m_tdata;
  logic           m_tvalid;
  logic [L-1:0]   m_tlast;

  logic           p_tready;
  logic [W*L-1:0] p_tdata;
  logic           p_tvalid;
  logic [L-1:0]   p_tlast;

  always #5 clk = ~clk;

  in128_out1536 #(.S_WIDTH(W), .LANES(L), .PAD_ON_LAST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  in128_out1536 #(.S_WIDTH(W), .LANES(L), .PAD_ON_LAST(1'b1)) dut_pad (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(p_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(p_tdata), .m_axis_tvalid(p_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(p_tlast)
  );

  typedef struct packed {
    logic [W*L-1:0] d;
    logic [L-1:0]   l;
  } word_t;

  typedef struct {
    logic         vld;
    logic [W-1:0] d;
    logic         last;
    logic         exp_mvld;
  } vec_t;

  word_t          sb[$];
  logic [W*L-1:0] mdl_d;
  logic [L-1:0]   mdl_l;
  int             mdl_n;
  int             acc_cnt;
  int             checks;
  int             failures;

  task automatic chk(input string name, input logic [W*L-1:0] act, input logic [W*L-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sample at negedge: score output handshakes, model accepted beats; then step one clock.
  task automatic cycle();
    word_t w;
    @(negedge clk);
    if (!rst && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        w = sb.pop_front();
        chk("word_data", m_tdata, w.d);
        chk("word_last", m_tlast, w.l);
      end
    end
    if (!rst && s_tvalid && s_tready) begin
      mdl_d[mdl_n*W +: W] = s_tdata;
      mdl_l[mdl_n]        = s_tlast;
      mdl_n++;
      acc_cnt++;
      if (mdl_n == L) begin
        w.d = mdl_d;
        w.l = mdl_l;
        sb.push_back(w);
        mdl_n = 0;
        mdl_d = '0;
        mdl_l = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    mdl_n = 0;
    mdl_d = '0;
    mdl_l = '0;
    sb.delete();
  endtask

  vec_t           tv[L+1];
  logic [W*L-1:0] exp_d;
  logic [W*L-1:0] held;
  int             start;

  initial begin
    checks = 0; failures = 0; mdl_n = 0; mdl_d = '0; mdl_l = '0; acc_cnt = 0;
    s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);

    // Table: twelve beats tdata=k, tlast on beat 11, then one idle step
    for (int k = 0; k < L; k++) begin
      tv[k].vld = 1'b1; tv[k].d = W'(k); tv[k].last = (k == L-1); tv[k].exp_mvld = 1'b0;
    end
    tv[L].vld = 1'b0; tv[L].d = '0; tv[L].last = 1'b0; tv[L].exp_mvld = 1'b1;
    exp_d = '0;
    for (int k = 0; k < L; k++) exp_d[k*W +: W] = W'(k);

    m_tready = 1'b1;
    for (int i = 0; i <= L; i++) begin
      s_tvalid = tv[i].vld; s_tdata = tv[i].d; s_tlast = tv[i].last;
      chk($sformatf("t1_mvld_%0d", i), m_tvalid, tv[i].exp_mvld);
      if (i == L) begin
        chk("t1_lanes", m_tdata, exp_d);
        chk("t1_tlast", m_tlast, 12'h800);
      end
      cycle();
    end

    // 36 back-to-back beats at full rate
    for (int i = 0; i < 36; i++) begin
      s_tvalid = 1'b1; s_tdata = W'(32'h1000 + i) << 64 | W'(i); s_tlast = (i % 5 == 4);
      chk("t2_s_tready", s_tready, 1);
      cycle();
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t2_drained", sb.size(), 0);

    // 24 beats with the output stalled
    m_tready = 1'b0;
    start = acc_cnt;
    for (int i = 0; i < 60 && acc_cnt - start < 24; i++) begin
      s_tvalid = 1'b1; s_tdata = W'(32'h3000 + acc_cnt); s_tlast = (acc_cnt % 7 == 0);
      cycle();
    end
    s_tvalid = 1'b0;
    chk("t3_fill_count", acc_cnt - start, 24);
    chk("t3_s_tready_low", s_tready, 0);
    chk("t3_m_tvalid", m_tvalid, 1);
    held = m_tdata;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold_data", m_tdata, held);
    end
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("t3_s_tready_back", s_tready, 1);
    chk("t3_drained", sb.size(), 0);

    // Reset after 7 accepted beats discards the partial word
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1; s_tdata = W'(32'hDEAD0000 + i); s_tlast = 1'b1;
      cycle();
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_output", m_tvalid, 0);
      cycle();
    end
    for (int i = 0; i < L; i++) begin
      s_tvalid = 1'b1; s_tdata = W'(32'h5500 + i); s_tlast = (i == 3 || i == 11);
      cycle();
    end
    s_tvalid = 1'b0;
    chk("t5_tlast", m_tlast, 12'h808);
    chk("t5_lane0", m_tdata[W-1:0], W'(32'h5500));
    cycle();
    chk("t5_drained", sb.size(), 0);

    // Random valid/ready/tlast stream through the scoreboard
    start = acc_cnt;
    for (int i = 0; i < 3000 && (acc_cnt - start < 120 || sb.size() != 0); i++) begin
      s_tvalid = (acc_cnt - start < 120) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_tlast  = 1'($urandom_range(0, 3) == 0);
      m_tready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("rand_count", acc_cnt - start, 120);
    chk("rand_drained", sb.size(), 0);
    chk("rand_partial", mdl_n, 0);

    // Early close with zero padding
    do_reset();
    m_tready = 1'b1;
    exp_d = '0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = W'(8'hA + i); s_tlast = (i == 4);
      exp_d[i*W +: W] = W'(8'hA + i);
      cycle();
    end
    s_tvalid = 1'b0;
    chk("pad_m_tvalid", p_tvalid, 1);
    chk("pad_data", p_tdata, exp_d);
    chk("pad_tlast", p_tlast, 12'h010);
    cycle();
    chk("pad_done", p_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in128_out1536.md
Name: in128_out1536

Overview:
- Upstream packer for the 1536-to-128 unpacker stage. Gathers twelve 128-bit AXI-Stream beats into one 1536-bit word.
- Records each beat's tlast in a 12-bit per-lane vector, so the downstream stage can reproduce the original 128-bit beat stream exactly.
- Sits between the 128-bit DMA/datamover stream and the 1536-bit systolic data route.
- Sustains 1 input beat/cycle while the output is not back-pressured.

Parameters:
- S_WIDTH, 128, input beat width in bits.
- LANES, 12, beats per output word; output width is S_WIDTH*LANES = 1536.
- PAD_ON_LAST, 0, when 1 an input tlast closes the word early and zero-pads the remaining lanes.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- s_axis_tdata  in  128  input beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; registered.
- s_axis_tlast  in  1  input end-of-packet.
- m_axis_tdata  out  1536  packed word; lane k occupies bits [128k+127:128k].
- m_axis_tvalid  out  1  output valid; registered.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  12  per-lane tlast vector; bit k is the tlast of lane k.

Behaviour:
- Lane order: the first accepted beat goes to lane 0 (bits [127:0], tlast bit 0). This matches the downstream right-shift unpack order.
- Storage: accumulator (acc_data, acc_last, lane_cnt 0..LANES-1), output register (out_data, out_last, m_axis_tvalid), and a flag acc_full.
- Reset values: lane_cnt=0, acc_full=0, m_axis_tvalid=0, s_axis_tready=1, m_axis_tdata=0, m_axis_tlast=0.
  - Reset mid-word discards the partial accumulator and any pending output without emitting it.
- s_axis_tready = ~acc_full.
- Accept: s_axis_tvalid & s_axis_tready. The beat is written into lane lane_cnt and lane_cnt increments.
- Word complete when the accepted beat is in lane LANES-1, or when PAD_ON_LAST=1 and s_axis_tlast=1.
  - Padded lanes (lane_cnt+1..LANES-1) get zero data and zero tlast bits.
- On word complete:
  - If (~m_axis_tvalid | m_axis_tready): the word, including the current beat, loads the output register next cycle and m_axis_tvalid=1.
  - Otherwise the word stays in the accumulator and acc_full=1.
  - In both cases lane_cnt returns to 0.
- Latency: completing beat accepted at cycle t gives m_axis_tvalid high at t+1.
- While acc_full:
  - No beats are accepted.
  - On m_axis_tready the accumulator moves to the output register, m_axis_tvalid stays 1, and acc_full clears. s_axis_tready rises the next cycle.
- Output handshake: m_axis_tvalid & m_axis_tready with no new word ready gives m_axis_tvalid=0 next cycle.
  - m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous events:
  - Word completion in the same cycle as an output handshake causes a direct reload; back-to-back full-rate throughput is 12 input cycles per output word.
  - An output handshake while acc_full reloads from the accumulator in that cycle.
- PAD_ON_LAST=0: tlast does not affect packing. Packets may straddle words; only the lane tlast bits mark boundaries.
- Data bits of unused lanes are never X; they are zero after reset or padding.

Decomposition:
- Shared package data_route_pkg holds:
  - S_WIDTH_128=128, LANES_12=12, WIDE_WIDTH=1536.
  - Lane-count width as $clog2(LANES).
- No sub-module. A single always-block datapath plus a small control path is sufficient.
- The output register is not factored into a separate skid module, because it is tied to acc_full.

Test Plan:
- Reset, then 12 beats with tdata=k (k=0..11), tlast only on beat 11, m_axis_tready=1 → one word, m_axis_tdata lane k = k, m_axis_tlast=12'h800, m_axis_tvalid one cycle after beat 11.
- 36 back-to-back beats with m_axis_tready=1 → 3 words, s_axis_tready constantly 1, no lost or duplicated lanes.
- 24 beats with m_axis_tready=0 throughout → first word held stable, acc_full=1 and s_axis_tready=0 after beat 24. Raise m_axis_tready → both words emitted in order, s_axis_tready returns 1.
- PAD_ON_LAST=1, 5 beats 0xA..0xE with tlast on beat 5 → lanes 0..4 = 0xA..0xE, lanes 5..11 = 0, m_axis_tlast=12'h010.
- Assert rst after 7 beats accepted → no output. Then 12 fresh beats → word contains only the new beats, m_axis_tlast from the new stream.
- Loopback through in1536_out128 with a random 128-bit stream, random valid/ready and random tlast → output stream bit-exact with the input, including tlast.
